// File: rtl/compression_decompression_engine_if.sv
// Command/result bundle for the dictionary compression engine.
// The master drives requests; the slave (engine) returns results and status.
interface compression_decompression_engine_if #(
    parameter int DATA_W = 80,
    parameter int CODE_W = 8
);
    logic [1:0]        command;
    logic [DATA_W-1:0] data_in;
    logic [CODE_W-1:0] compressed_in;
    logic [CODE_W-1:0] compressed_out;
    logic [DATA_W-1:0] decompressed_out;
    logic [1:0]        response;
    logic              busy;

    modport master (
        output command, data_in, compressed_in,
        input  compressed_out, decompressed_out, response, busy
    );

    modport slave (
        input  command, data_in, compressed_in,
        output compressed_out, decompressed_out, response, busy
    );
endinterface

// File: rtl/compression_decompression_engine.sv
// Dictionary-based word compressor: linear search over the dictionary to find or insert,
// and direct indexed lookup to expand a code back into its word.
module compression_decompression_engine #(
    parameter int DATA_W = 80,
    parameter int CODE_W = 8,
    parameter int DEPTH  = 2**CODE_W
) (
    input logic clk,
    input logic reset,
    compression_decompression_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, READ, RESP} state_e;

    localparam logic [1:0] CMD_COMP = 2'b01;
    localparam logic [1:0] CMD_DECO = 2'b10;
    localparam logic [1:0] CMD_BAD  = 2'b11;
    localparam logic [1:0] ST_OK    = 2'b01;
    localparam logic [1:0] ST_ERR   = 2'b10;
    localparam logic [1:0] ST_INV   = 2'b11;
    localparam logic [CODE_W:0] DEPTH_C = (CODE_W+1)'(DEPTH);

    state_e              state_q, state_d;
    logic [CODE_W:0]     j_q, j_d;
    logic [CODE_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [1:0]          status_q, status_d;
    logic [CODE_W-1:0]   comp_out_q, comp_out_d;
    logic [DATA_W-1:0]   decomp_out_q, decomp_out_d;

    // Dictionary is never reset; cnt alone decides which entries are valid.
    logic [DATA_W-1:0]   dict_q [DEPTH];
    logic                dict_we;
    logic [CODE_W-1:0]   rd_idx;
    logic [DATA_W-1:0]   rd_entry;
    logic                hit;
    logic                code_valid;

    assign rd_idx     = (state_q == READ) ? code_q : j_q[CODE_W-1:0];
    assign rd_entry   = dict_q[rd_idx];
    assign hit        = (j_q < cnt_q) && (rd_entry == data_q);
    assign code_valid = ({1'b0, code_q} < cnt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            j_q          <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            code_q       <= '0;
            status_q     <= '0;
            comp_out_q   <= '0;
            decomp_out_q <= '0;
        end else begin
            state_q      <= state_d;
            j_q          <= j_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            code_q       <= code_d;
            status_q     <= status_d;
            comp_out_q   <= comp_out_d;
            decomp_out_q <= decomp_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dict_we && !reset) dict_q[cnt_q[CODE_W-1:0]] <= data_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                case (bus.command)
                    CMD_COMP: state_d = SEARCH;
                    CMD_DECO: state_d = READ;
                    CMD_BAD:  state_d = RESP;
                    default:  state_d = IDLE;
                endcase
            end
            SEARCH:  if (hit || (j_q == cnt_q)) state_d = RESP;
            READ:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        j_d          = j_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        code_d       = code_q;
        status_d     = status_q;
        comp_out_d   = comp_out_q;
        decomp_out_d = decomp_out_q;
        dict_we      = 1'b0;
        case (state_q)
            IDLE: begin
                case (bus.command)
                    CMD_COMP: begin
                        data_d = bus.data_in;
                        j_d    = '0;
                    end
                    CMD_DECO: code_d   = bus.compressed_in;
                    CMD_BAD:  status_d = ST_INV;
                    default: ;
                endcase
            end
            SEARCH: begin
                if (hit) begin
                    comp_out_d = j_q[CODE_W-1:0];
                    status_d   = ST_OK;
                end else if (j_q == cnt_q) begin
                    // Reached the end of valid entries without a match: append if room.
                    if (cnt_q < DEPTH_C) begin
                        dict_we    = 1'b1;
                        comp_out_d = cnt_q[CODE_W-1:0];
                        cnt_d      = cnt_q + 1'b1;
                        status_d   = ST_OK;
                    end else begin
                        status_d   = ST_ERR;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            READ: begin
                if (code_valid) begin
                    decomp_out_d = rd_entry;
                    status_d     = ST_OK;
                end else begin
                    status_d     = ST_ERR;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.response         = (state_q == RESP) ? status_q : 2'b00;
        bus.busy             = (state_q != IDLE);
        bus.compressed_out   = comp_out_q;
        bus.decompressed_out = decomp_out_q;
    end
endmodule

// File: tb/tb_compression_decompression_engine.sv
// Directed scoreboard bench: stimulus pushes expected responses (status, cycle, outputs),
// a negedge monitor pops and checks each response the engine presents.
module tb_compression_decompression_engine;
    localparam int DATA_W = 80;
    localparam int CODE_W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [1:0]        resp;
        int                at;
        bit                chk_code;
        logic [CODE_W-1:0] code;
        bit                chk_data;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];

    compression_decompression_engine_if #(.DATA_W(DATA_W), .CODE_W(CODE_W)) bus ();

    compression_decompression_engine #(.DATA_W(DATA_W), .CODE_W(CODE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.response != 2'b00) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got %b want none (cycle %0d)", bus.response, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp", DATA_W'(bus.response), DATA_W'(e.resp));
                chk("resp_cycle", DATA_W'(cyc), DATA_W'(e.at));
                if (e.chk_code) chk("code_out", DATA_W'(bus.compressed_out), DATA_W'(e.code));
                if (e.chk_data) chk("data_out", bus.decompressed_out, e.data);
            end
        end
    end

    // Drive a command for one sampling edge; response is expected lat cycles after that edge.
    task automatic issue(input logic [1:0] cmd, input logic [DATA_W-1:0] din,
                         input logic [CODE_W-1:0] cin, input bit push,
                         input logic [1:0] resp, input int lat,
                         input bit cc, input logic [CODE_W-1:0] code,
                         input bit cd, input logic [DATA_W-1:0] data);
        exp_t e;
        @(posedge clk);
        #1;
        bus.command       = cmd;
        bus.data_in       = din;
        bus.compressed_in = cin;
        if (push) begin
            e.resp = resp; e.at = cyc + lat;
            e.chk_code = cc; e.code = code;
            e.chk_data = cd; e.data = data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.command = 2'b00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        total++;
        bad++;
        $display("FAIL idle_timeout: busy stuck high want low (cycle %0d)", cyc);
    endtask

    task automatic comp(input logic [DATA_W-1:0] w, input logic [1:0] resp, input int lat,
                        input logic [CODE_W-1:0] code);
        issue(2'b01, w, '0, 1'b1, resp, lat, 1'b1, code, 1'b0, '0);
        wait_idle();
    endtask

    task automatic deco(input logic [CODE_W-1:0] c, input logic [1:0] resp,
                        input logic [DATA_W-1:0] data);
        issue(2'b10, '0, c, 1'b1, resp, 2, 1'b0, '0, 1'b1, data);
        wait_idle();
    endtask

    initial begin
        bus.command       = 2'b00;
        bus.data_in       = '0;
        bus.compressed_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_resp", DATA_W'(bus.response), '0);
        chk("rst_busy", DATA_W'(bus.busy), '0);
        chk("rst_code", DATA_W'(bus.compressed_out), '0);
        chk("rst_data", bus.decompressed_out, '0);

        // First insert, with busy observed across both engine cycles.
        issue(2'b01, 80'h1, '0, 1'b1, 2'b01, 2, 1'b1, 8'h00, 1'b0, '0);
        @(negedge clk);
        chk("busy_n1", DATA_W'(bus.busy), 80'h1);
        @(negedge clk);
        chk("busy_n2", DATA_W'(bus.busy), 80'h1);
        wait_idle();

        comp(80'h1, 2'b01, 2, 8'h00);
        comp(80'h2, 2'b01, 3, 8'h01);
        deco(8'h01, 2'b01, 80'h2);
        deco(8'h05, 2'b10, 80'h2);
        chk("code_hold", DATA_W'(bus.compressed_out), 80'h01);

        issue(2'b11, '0, '0, 1'b1, 2'b11, 1, 1'b1, 8'h01, 1'b1, 80'h2);
        wait_idle();

        // A compress request while busy must be dropped entirely.
        issue(2'b01, 80'h1, '0, 1'b1, 2'b01, 2, 1'b1, 8'h00, 1'b0, '0);
        bus.command = 2'b01;
        bus.data_in = 80'h77;
        @(posedge clk);
        #1 bus.command = 2'b00;
        wait_idle();
        deco(8'h02, 2'b10, 80'h2);

        for (int w = 3; w <= 256; w++) comp(DATA_W'(w), 2'b01, w + 1, CODE_W'(w - 1));
        comp(80'h101, 2'b10, 258, 8'hFF);
        comp(80'h100, 2'b01, 257, 8'hFF);
        deco(8'hFF, 2'b01, 80'h100);
        deco(8'h80, 2'b01, 80'h81);

        // Reset mid-search with a command present on the same edge.
        issue(2'b01, 80'h999, '0, 1'b0, 2'b00, 0, 1'b0, '0, 1'b0, '0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.command = 2'b01;
        bus.data_in = 80'h55;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.command = 2'b00;
        @(negedge clk);
        chk("mid_rst_resp", DATA_W'(bus.response), '0);
        chk("mid_rst_busy", DATA_W'(bus.busy), '0);
        chk("mid_rst_code", DATA_W'(bus.compressed_out), '0);
        chk("mid_rst_data", bus.decompressed_out, '0);
        deco(8'h00, 2'b10, 80'h0);
        comp(80'h55, 2'b01, 2, 8'h00);
        deco(8'h00, 2'b01, 80'h55);

        repeat (3) @(negedge clk);
        chk("sb_empty", DATA_W'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim still running want finished");
        $fatal(1);
    end
endmodule

// File: doc/compression_decompression_engine.md
COMPRESSION_DECOMPRESSION_ENGINE -- requirements
Module: compression_decompression_engine

Interface
REQ-001 Parameters: DATA_W, default 80, uncompressed word width.
REQ-002 Parameters: CODE_W, default 8, compressed code width.
REQ-003 Parameters: DEPTH, default 2**CODE_W (256), number of dictionary entries.
REQ-004 The module SHALL have a single clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be:
- clk, input, 1, sole clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-high reset.
- command, input, 2, operation request: 00 none, 01 compress, 10 decompress, 11 invalid.
- data_in, input, DATA_W, word to compress.
- compressed_in, input, CODE_W, code to decompress.
- compressed_out, output, CODE_W, code result of last successful compress.
- decompressed_out, output, DATA_W, word result of last successful decompress.
- response, output, 2, one-cycle status: 00 none, 01 ok, 10 error (dictionary full or code invalid), 11 invalid command.
- busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-006 FSM states SHALL be IDLE, SEARCH, READ and RESP.
REQ-007 Commands SHALL be sampled only in IDLE; command, data_in and compressed_in are ignored in every other state.
REQ-008 Command transitions out of IDLE:
- 00: stay in IDLE.
- 01: latch data_in, set search index j=0, go to SEARCH.
- 10: latch compressed_in, go to READ.
- 11: go to RESP with status 11.
REQ-009 The dictionary SHALL be a DEPTH x DATA_W array with an entry count register cnt (0..DEPTH); entries at index >= cnt are invalid.
REQ-010 SEARCH SHALL examine one entry per cycle, entry j in the j-th SEARCH cycle (j from 0).
REQ-011 SEARCH hit: if j < cnt and dict[j] == latched data, compressed_out <= j and status 01, then go to RESP.
REQ-012 SEARCH miss with space: if j == cnt and cnt < DEPTH, then dict[cnt] <= data, compressed_out <= cnt, cnt <= cnt+1, status 01, then go to RESP.
REQ-013 SEARCH miss with dictionary full: if j == cnt == DEPTH, status 10; compressed_out and cnt are unchanged; go to RESP.
REQ-014 Compress latency, command sampled at cycle N:
- hit at index k: response at N+k+2.
- miss with cnt=c: response at N+c+2.
REQ-015 READ: if latched code < cnt, decompressed_out <= dict[code] and status 01; otherwise status 10 and decompressed_out is unchanged. Then go to RESP.
REQ-016 Decompress response SHALL appear at N+2; invalid-command response SHALL appear at N+1.
REQ-017 In RESP, response SHALL drive the stored status for exactly one cycle, then the FSM returns to IDLE. response SHALL be 00 in every other state.
REQ-018 The earliest next command is accepted in the cycle after RESP.
REQ-019 compressed_out and decompressed_out SHALL hold their values until overwritten by a successful operation of the same kind.
REQ-020 Duplicate words SHALL never be inserted; cnt SHALL never exceed DEPTH or wrap.
REQ-021 Code comparisons SHALL be done with width CODE_W+1 so that cnt == DEPTH is representable.

Reset
REQ-022 When reset is high at a clock edge, the following SHALL apply and take priority over any operation in progress (SEARCH, READ, RESP):
- state <= IDLE, cnt <= 0.
- compressed_out <= 0, decompressed_out <= 0, response <= 00, busy <= 0.
REQ-023 Dictionary contents SHALL NOT be reset; validity is governed solely by cnt.
REQ-024 A command present in the same cycle as reset SHALL be ignored.

Verification
REQ-025 Reset, then compress 80'h1 at cycle N -> response 01 at N+2, compressed_out 8'h00, busy high during N+1..N+2.
REQ-026 Compress 80'h1 again -> response 01 at N+2 with code 8'h00 and cnt stays 1; then compress 80'h2 -> response 01 at N+3 with code 8'h01.
REQ-027 Decompress 8'h01 -> response 01 at N+2, decompressed_out 80'h2; then decompress 8'h05 with cnt=2 -> response 10 at N+2, decompressed_out stays 80'h2.
REQ-028 Insert 256 distinct words, then compress a 257th distinct word -> response 10 at N+258 and compressed_out unchanged; compress an existing word at index 255 -> response 01 with code 8'hFF.
REQ-029 Command 11 -> response 11 at N+1; a command 01 applied while busy is ignored, so cnt is unchanged and no extra response occurs.
REQ-030 Assert reset during SEARCH -> next cycle response 00, busy 0, outputs 0; a subsequent decompress of 8'h00 -> response 10.
